// File: rtl/lc3_pkg.sv
// lc3_pkg: opcode, FSM state and halt-cause constants shared by the LC3 control path.
// Also carries the TRAP vector that stops the core.
package lc3_pkg;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_RTI  = 4'b1000;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_RES  = 4'b1101;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    localparam logic [3:0] S_FETCH0  = 4'd0;
    localparam logic [3:0] S_FETCH1  = 4'd1;
    localparam logic [3:0] S_DECODE  = 4'd2;
    localparam logic [3:0] S_EXEC    = 4'd3;
    localparam logic [3:0] S_MEM_IND = 4'd4;
    localparam logic [3:0] S_MEM_RD  = 4'd5;
    localparam logic [3:0] S_MEM_WR  = 4'd6;
    localparam logic [3:0] S_WB      = 4'd7;
    localparam logic [3:0] S_HALT    = 4'd8;
    localparam logic [3:0] S_PAUSE   = 4'd9;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    localparam logic [7:0] TRAP_HALT = 8'h25;

    function automatic logic is_mem_state(input logic [3:0] s);
        return (s == S_MEM_IND) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/lc3_mem_wait.sv
// lc3_mem_wait: counts MEM_READY-low cycles in a memory state and flags
// the cycle in which the wait budget runs out.
module lc3_mem_wait
    import lc3_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       ready_i,
    input  logic [7:0] limit_i,
    output logic       done_o,
    output logic       timeout_o
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = '0;
        end else if (!ready_i && cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Ready wins over timeout when both land in the last allowed cycle.
    assign done_o    = ready_i;
    assign timeout_o = !ready_i && (cnt_q == limit_i - 8'd1);

endmodule

// File: rtl/lc3_sequencer.sv
// lc3_sequencer: multi-cycle LC3 control FSM (fetch, decode, memory, writeback, halt).
// Optional single-step pause state is enabled by LC3_SEQ_SINGLE_STEP_EN.
module lc3_sequencer
    import lc3_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] IR,
    input  logic [2:0]  NZP,
    input  logic        MEM_READY,
`ifdef LC3_SEQ_SINGLE_STEP_EN
    input  logic        STEP,
`endif
    output logic        PC_LE,
    output logic        IR_LE,
    output logic        PC_CONTROL,
    output logic        RF_WE,
    output logic        CC_LE,
    output logic        MEM_RE,
    output logic        MEM_WE,
    output logic        ADDR_IND,
    output logic        HALTED,
    output logic [1:0]  ERROR,
    output logic [15:0] INSTR_COUNT
);

`ifdef LC3_SEQ_SINGLE_STEP_EN
    localparam logic [3:0] S_RETIRE = S_PAUSE;
`else
    localparam logic [3:0] S_RETIRE = S_FETCH0;
`endif

    logic [3:0]  state_q, state_d;
    logic [1:0]  error_q, error_d;
    logic        halted_q;
    logic [15:0] count_q;
    logic        retire;
    logic        mem_start, mem_done, mem_timeout;
    logic        unused_ir8;

    logic [3:0] op;
    logic       taken, is_alu, is_link;
    logic       is_halt_trap, is_illegal, is_load, is_ind, is_store;

    assign op         = IR[15:12];
    assign unused_ir8 = IR[8];
    assign taken      = |(IR[11:9] & NZP);
    assign is_alu     = (op == OP_ADD) || (op == OP_AND) ||
                        (op == OP_NOT) || (op == OP_LEA);
    assign is_link    = (op == OP_JSR) || (op == OP_TRAP);
    assign is_halt_trap = (op == OP_TRAP) && (IR[7:0] == TRAP_HALT);
    assign is_illegal = (op == OP_RTI) || (op == OP_RES);
    assign is_load    = (op == OP_LD) || (op == OP_LDR);
    assign is_ind     = (op == OP_LDI) || (op == OP_STI);
    assign is_store   = (op == OP_ST) || (op == OP_STR);

    always_comb begin
        state_d = state_q;
        error_d = error_q;
        retire  = 1'b0;
        unique case (state_q)
            S_FETCH0: state_d = S_FETCH1;
            S_FETCH1: state_d = S_DECODE;
            S_DECODE: begin
                unique case (1'b1)
                    is_halt_trap: begin
                        state_d = S_HALT;
                        error_d = ERR_NONE;
                    end
                    is_illegal: begin
                        state_d = S_HALT;
                        error_d = ERR_ILLEGAL;
                    end
                    is_load:  state_d = S_MEM_RD;
                    is_ind:   state_d = S_MEM_IND;
                    is_store: state_d = S_MEM_WR;
                    default:  state_d = S_EXEC;
                endcase
            end
            S_EXEC, S_WB: begin
                state_d = S_RETIRE;
                retire  = 1'b1;
            end
            S_MEM_IND, S_MEM_RD, S_MEM_WR: begin
                if (mem_done) begin
                    if (state_q == S_MEM_IND) begin
                        state_d = (op == OP_LDI) ? S_MEM_RD : S_MEM_WR;
                    end else if (state_q == S_MEM_RD) begin
                        state_d = S_WB;
                    end else begin
                        state_d = S_RETIRE;
                        retire  = 1'b1;
                    end
                end else if (mem_timeout) begin
                    state_d = S_HALT;
                    error_d = ERR_TIMEOUT;
                end
            end
            S_HALT: state_d = S_HALT;
`ifdef LC3_SEQ_SINGLE_STEP_EN
            S_PAUSE: begin
                if (STEP) begin
                    state_d = S_FETCH0;
                end
            end
`endif
            default: state_d = S_FETCH0;
        endcase
    end

    assign mem_start = is_mem_state(state_d) && (state_d != state_q);

    lc3_mem_wait u_wait (
        .clk_i     (CLK),
        .rst_i     (RST),
        .start_i   (mem_start),
        .ready_i   (MEM_READY),
        .limit_i   (8'(MEM_TIMEOUT)),
        .done_o    (mem_done),
        .timeout_o (mem_timeout)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_FETCH0;
            error_q  <= ERR_NONE;
            halted_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            error_q  <= error_d;
            halted_q <= (state_d == S_HALT);
            count_q  <= count_q + {15'd0, retire};
        end
    end

    // Strobes are pure decode of state, so an async reset kills them at once.
    always_comb begin
        PC_LE      = 1'b0;
        IR_LE      = 1'b0;
        PC_CONTROL = 1'b0;
        RF_WE      = 1'b0;
        CC_LE      = 1'b0;
        MEM_RE     = 1'b0;
        MEM_WE     = 1'b0;
        ADDR_IND   = 1'b0;
        unique case (state_q)
            S_FETCH1: begin
                IR_LE = 1'b1;
                PC_LE = 1'b1;
            end
            S_EXEC: begin
                unique case (1'b1)
                    is_alu: begin
                        RF_WE = 1'b1;
                        CC_LE = 1'b1;
                    end
                    (op == OP_BR): begin
                        PC_LE      = taken;
                        PC_CONTROL = taken;
                    end
                    (op == OP_JMP): begin
                        PC_LE      = 1'b1;
                        PC_CONTROL = 1'b1;
                    end
                    is_link: begin
                        RF_WE      = 1'b1;
                        PC_LE      = 1'b1;
                        PC_CONTROL = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM_IND: MEM_RE = 1'b1;
            S_MEM_RD: begin
                MEM_RE   = 1'b1;
                ADDR_IND = (op == OP_LDI);
            end
            S_MEM_WR: begin
                MEM_WE   = 1'b1;
                ADDR_IND = (op == OP_STI);
            end
            S_WB: begin
                RF_WE = 1'b1;
                CC_LE = 1'b1;
            end
            default: ;
        endcase
    end

    assign HALTED      = halted_q;
    assign ERROR       = error_q;
    assign INSTR_COUNT = count_q;

endmodule

// File: tb/tb_lc3_sequencer.sv
// tb_lc3_sequencer: directed instruction sequence; per-cycle expected strobe
// vectors and MEM_READY stimulus are queued, then popped and compared.
module tb_lc3_sequencer;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] IR = 16'h0000;
    logic [2:0]  NZP = 3'b000;
    logic        MEM_READY = 1'b0;
    logic        PC_LE, IR_LE, PC_CONTROL, RF_WE, CC_LE;
    logic        MEM_RE, MEM_WE, ADDR_IND, HALTED;
    logic [1:0]  ERROR;
    logic [15:0] INSTR_COUNT;

    localparam logic [10:0] B_PCLE = 11'h400;
    localparam logic [10:0] B_IRLE = 11'h200;
    localparam logic [10:0] B_PCC  = 11'h100;
    localparam logic [10:0] B_RFWE = 11'h080;
    localparam logic [10:0] B_CCLE = 11'h040;
    localparam logic [10:0] B_RE   = 11'h020;
    localparam logic [10:0] B_WE   = 11'h010;
    localparam logic [10:0] B_IND  = 11'h008;
    localparam logic [10:0] B_HLT  = 11'h004;

    int n_pass  = 0;
    int n_total = 0;

    logic [10:0] exp_q[$];
    logic        rdy_q[$];
    logic [10:0] obs;

    assign obs = {PC_LE, IR_LE, PC_CONTROL, RF_WE, CC_LE,
                  MEM_RE, MEM_WE, ADDR_IND, HALTED, ERROR};

    lc3_sequencer #(.MEM_TIMEOUT(15)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .IR          (IR),
        .NZP         (NZP),
        .MEM_READY   (MEM_READY),
        .PC_LE       (PC_LE),
        .IR_LE       (IR_LE),
        .PC_CONTROL  (PC_CONTROL),
        .RF_WE       (RF_WE),
        .CC_LE       (CC_LE),
        .MEM_RE      (MEM_RE),
        .MEM_WE      (MEM_WE),
        .ADDR_IND    (ADDR_IND),
        .HALTED      (HALTED),
        .ERROR       (ERROR),
        .INSTR_COUNT (INSTR_COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] o,
                       input logic [15:0] e);
        n_total++;
        assert (o === e) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, o, e);
    endtask

    task automatic push(input logic [10:0] e, input logic r);
        exp_q.push_back(e);
        rdy_q.push_back(r);
    endtask

    task automatic push_n(input int n, input logic [10:0] e, input logic r);
        for (int i = 0; i < n; i++) push(e, r);
    endtask

    task automatic push_fetch(input logic r);
        push(11'h000, r);
        push(B_PCLE | B_IRLE, r);
        push(11'h000, r);
    endtask

    task automatic drain(input string tag);
        int cyc;
        logic [10:0] e;
        cyc = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            MEM_READY = rdy_q.pop_front();
            @(negedge CLK);
            chk($sformatf("%s c%0d", tag, cyc), {5'b0, obs}, {5'b0, e});
            cyc++;
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        MEM_READY = 1'b0;
        @(posedge CLK);
        #1;
        @(negedge CLK);
        chk("reset strobes", {5'b0, obs}, 16'h0000);
        chk("reset count", INSTR_COUNT, 16'h0000);
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();

        IR = 16'h1261;
        push_fetch(1'b0); push(B_RFWE | B_CCLE, 1'b0); drain("add");
        chk("add count", INSTR_COUNT, 16'd1);

        IR = 16'h927F;
        push_fetch(1'b1); push(B_RFWE | B_CCLE, 1'b1); drain("not rdy");

        IR = 16'h0403; NZP = 3'b010;
        push_fetch(1'b0); push(B_PCLE | B_PCC, 1'b0); drain("brz taken");
        NZP = 3'b100;
        push_fetch(1'b0); push(11'h000, 1'b0); drain("brz not");
        IR = 16'h0001; NZP = 3'b010;
        push_fetch(1'b0); push(11'h000, 1'b0); drain("br none");

        IR = 16'hC1C0;
        push_fetch(1'b0); push(B_PCLE | B_PCC, 1'b0); drain("jmp");
        IR = 16'h4800;
        push_fetch(1'b0); push(B_RFWE | B_PCLE | B_PCC, 1'b0); drain("jsr");
        IR = 16'hF023;
        push_fetch(1'b0); push(B_RFWE | B_PCLE | B_PCC, 1'b0); drain("trap23");
        IR = 16'hE005;
        push_fetch(1'b0); push(B_RFWE | B_CCLE, 1'b0); drain("lea");
        IR = 16'h5020;
        push_fetch(1'b0); push(B_RFWE | B_CCLE, 1'b0); drain("and");
        chk("exec count", INSTR_COUNT, 16'd10);

        IR = 16'h2002;
        push_fetch(1'b0); push(B_RE, 1'b0); push(B_RE, 1'b1);
        push(B_RFWE | B_CCLE, 1'b0); drain("ld");
        IR = 16'h6042;
        push_fetch(1'b0); push(B_RE, 1'b1);
        push(B_RFWE | B_CCLE, 1'b0); drain("ldr");
        IR = 16'hA005;
        push_fetch(1'b0);
        push_n(2, B_RE, 1'b0); push(B_RE, 1'b1);
        push_n(2, B_RE | B_IND, 1'b0); push(B_RE | B_IND, 1'b1);
        push(B_RFWE | B_CCLE, 1'b0); drain("ldi");
        IR = 16'hB005;
        push_fetch(1'b0); push(B_RE, 1'b1); push(B_WE | B_IND, 1'b1);
        drain("sti");
        IR = 16'h7042;
        push_fetch(1'b0); push(B_WE, 1'b1); drain("str");
        IR = 16'h3002;
        push_fetch(1'b0); push_n(14, B_WE, 1'b0); push(B_WE, 1'b1);
        drain("st last-cycle ready");
        chk("mem count", INSTR_COUNT, 16'd16);

        push_fetch(1'b0); drain("st pre-reset");
        MEM_READY = 1'b0;
        @(negedge CLK);
        chk("st we before rst", {15'b0, MEM_WE}, 16'd1);
        #2 RST = 1'b1;
        #1 chk("st we on rst", {15'b0, MEM_WE}, 16'd0);
        chk("rst count clear", INSTR_COUNT, 16'd0);
        @(posedge CLK);
        #1 RST = 1'b0;
        IR = 16'h1261;
        push_fetch(1'b0); push(B_RFWE | B_CCLE, 1'b0); drain("post-rst add");
        chk("post-rst count", INSTR_COUNT, 16'd1);

        IR = 16'h3002;
        push_fetch(1'b0); push_n(15, B_WE, 1'b0);
        push_n(2, B_HLT | 11'd2, 1'b0); push_n(2, B_HLT | 11'd2, 1'b1);
        drain("st timeout");
        chk("timeout count", INSTR_COUNT, 16'd1);

        do_reset();
        IR = 16'h1261;
        push_fetch(1'b0); push(B_RFWE | B_CCLE, 1'b0); drain("add2");
        IR = 16'hF025;
        push_fetch(1'b0); push_n(3, B_HLT, 1'b1); drain("trap25");
        chk("trap25 count", INSTR_COUNT, 16'd1);

        do_reset();
        IR = 16'hD000;
        push_fetch(1'b0); push_n(2, B_HLT | 11'd1, 1'b0); drain("reserved");
        chk("reserved count", INSTR_COUNT, 16'd0);

        do_reset();
        IR = 16'h8000;
        push_fetch(1'b0); push_n(2, B_HLT | 11'd1, 1'b0); drain("rti");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lc3_sequencer.md
# lc3_sequencer

Multi-cycle control FSM for the LC3 core. Drives the instruction fetch stage's load enables and PC source select, decodes the opcode in IR, and sequences register-file, condition-code and data-memory strobes for each instruction. It retires one instruction at a time, halts on TRAP x25 or an illegal opcode, and flags data-memory handshake timeouts.

## Interface
- `MEM_TIMEOUT`, default 15: maximum cycles to wait for `MEM_READY` before an error halt; range 1..255.
- `CLK`  in  1: system clock; all state changes on the rising edge.
- `RST`  in  1: asynchronous, active-high reset.
- `IR`  in  16: current instruction register from the fetch stage.
- `NZP`  in  3: condition codes {N,Z,P} from the datapath.
- `MEM_READY`  in  1: data memory has completed the current read or write.
- `PC_LE`  out  1: PC load enable to the fetch stage.
- `IR_LE`  out  1: IR load enable to the fetch stage.
- `PC_CONTROL`  out  1: 1 selects datapath `Y` as the next PC; 0 selects PC+1.
- `RF_WE`  out  1: register-file write enable.
- `CC_LE`  out  1: condition-code load enable.
- `MEM_RE`  out  1: data-memory read request.
- `MEM_WE`  out  1: data-memory write request.
- `ADDR_IND`  out  1: 1 selects MDR as the memory address (second access of LDI/STI).
- `HALTED`  out  1: core is stopped.
- `ERROR`  out  2: halt cause; 0 none/TRAP, 1 illegal opcode, 2 memory timeout.
- `INSTR_COUNT`  out  16: count of retired instructions.

## Operation
- States:
  - `FETCH0`: no strobes; the instruction RAM samples PC.
  - `FETCH1`: `IR_LE=1`, `PC_LE=1`, `PC_CONTROL=0`.
  - `DECODE`
  - `EXEC`
  - `MEM_IND`
  - `MEM_RD`
  - `MEM_WR`
  - `WB`
  - `HALT`
- `DECODE` dispatches on `IR[15:12]`:
  - ADD, AND, NOT, LEA → `EXEC`. Asserts `RF_WE=1`, `CC_LE=1`, then → `FETCH0`.
  - BR → `EXEC`. Taken = `|(IR[11:9] & NZP)`. `PC_LE=PC_CONTROL=taken`.
  - JMP → `EXEC`. `PC_LE=1`, `PC_CONTROL=1`.
  - JSR → `EXEC`. `RF_WE=1` (R7 link), `PC_LE=1`, `PC_CONTROL=1`.
  - LD, LDR → `MEM_RD`.
  - LDI → `MEM_IND` → `MEM_RD` with `ADDR_IND=1`.
  - ST, STR → `MEM_WR`.
  - STI → `MEM_IND` → `MEM_WR` with `ADDR_IND=1`.
  - TRAP with `IR[7:0]==8'h25` → `HALT`, `ERROR=0`.
  - Any other TRAP → `EXEC`. `RF_WE=1`, `PC_LE=1`, `PC_CONTROL=1`.
  - RTI (1000) and reserved (1101) → `HALT`, `ERROR=1`.
- Memory states (`MEM_IND`, `MEM_RD`, `MEM_WR`):
  - Hold `MEM_RE` (or `MEM_WE`) high until the cycle `MEM_READY=1`, inclusive, then advance.
  - `MEM_RD` → `WB`. `WB` asserts `RF_WE=1`, `CC_LE=1`, then → `FETCH0`.
  - `MEM_WR` → `FETCH0`.
- Timeout:
  - An 8-bit wait counter clears on entry to each memory state.
  - It increments every cycle `MEM_READY=0`.
  - When it reaches `MEM_TIMEOUT` → `HALT`, `ERROR=2`.
- `INSTR_COUNT` increments (wrapping at 16'hFFFF → 0) on each transition into `FETCH0` from a non-reset state. Halting instructions are not counted.
- `HALT` is absorbing: all strobes are 0 and `HALTED=1`. Only `RST` exits it.
- All strobe outputs are decoded from state and `IR`/`NZP`/`MEM_READY`. No strobe is asserted outside the states listed above.

## Timing
- Reset values:
  - State `FETCH0`.
  - All strobes 0.
  - `HALTED=0`, `ERROR=0`, `INSTR_COUNT=0`, wait counter 0.
- `RST` mid-instruction drops every strobe asynchronously. No partial write completes after `RST` rises.
- Instruction latency (cycles, `FETCH0` to next `FETCH0`):
  - ALU, BR, JMP, JSR, TRAP: 4.
  - LD/LDR: 5+w.
  - ST/STR: 4+w.
  - LDI: 6+w1+w2.
  - STI: 5+w1+w2.
  - w is the number of `MEM_READY`-low cycles.
- `MEM_READY` asserted in the first cycle of a memory state gives w=0.
- `MEM_READY` outside memory states is ignored.
- `MEM_READY` arriving in the same cycle the timeout is reached counts as success.
- `HALTED` and `ERROR` are registered and valid the cycle after the halting condition.

## Configuration
- `LC3_SEQ_SINGLE_STEP_EN` defined:
  - Adds input `STEP` (1 bit) and state `PAUSE`.
  - Every transition that would enter `FETCH0` enters `PAUSE` instead.
  - `PAUSE` holds all strobes at 0 and advances to `FETCH0` on a cycle with `STEP=1`.
  - `INSTR_COUNT` still increments on entry to `PAUSE`.
- Undefined: no `STEP` port and no `PAUSE` state; behaviour is exactly as above.

## Structure
- Shared package `lc3_pkg` holds:
  - The opcode constants (`OP_BR`..`OP_TRAP`).
  - The state enumeration.
  - The `ERROR` code constants.
  - The `TRAP_HALT` vector constant 8'h25.
- One sub-module, `lc3_mem_wait`: the wait counter and timeout compare. Inputs are start, ready and limit; outputs are done and timeout.

## Test plan
- Reset, then ADD (16'h1261), `MEM_READY` tied 0 → sequence of strobes:
  - `IR_LE=PC_LE=1` in cycle 2.
  - `RF_WE=CC_LE=1` in cycle 4.
  - `INSTR_COUNT=1` after 4 cycles.
- BRz (16'h0403):
  - With `NZP=3'b010`: `PC_LE=PC_CONTROL=1` in `EXEC`.
  - With `NZP=3'b100`: `PC_LE=0` in `EXEC`.
- LDI (16'hA005), `MEM_READY` after 2 wait cycles on each access:
  - `MEM_RE` high for 3 cycles with `ADDR_IND=0`, then 3 cycles with `ADDR_IND=1`.
  - Then `WB` with `RF_WE=1`.
  - Total 10 cycles.
- ST (16'h3002), `MEM_READY` held 0 → after 15 wait cycles:
  - `HALTED=1`, `ERROR=2`.
  - `MEM_WE=0` thereafter.
- TRAP x25 (16'hF025) → `HALTED=1`, `ERROR=0`, `INSTR_COUNT` unchanged. Opcode 1101 → `HALTED=1`, `ERROR=1`.
- Assert `RST` during `MEM_WR` with `MEM_WE=1`:
  - `MEM_WE` falls in the same cycle.
  - After release, the FSM is in `FETCH0` and `INSTR_COUNT=0`.
